// File: rtl/timebase_pkg.sv
// Shared types, reset defaults and the config validity rule for the timebase controller.
package timebase_pkg;

    typedef enum logic [1:0] {IDLE, RUN_HIGH, RUN_LOW} tb_state_t;

    localparam int DEF_HIGH_C   = 500;
    localparam int DEF_PERIOD_C = 10000;

    // A usable config needs at least one high and one low cycle per period.
    function automatic logic cfg_ok(input logic [31:0] high, input logic [31:0] period);
        return (period >= 32'd2) && (high >= 32'd1) && (high <= period - 32'd1);
    endfunction

endpackage

// File: rtl/tb_period_counter.sv
// Wrapping cycle counter: counts 0..limit_i, flags the last cycle, clears synchronously.
module tb_period_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_last_o = (cnt_q == limit_i);
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = at_last_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timebase_ctrl.sv
// Programmable timebase: divided waveform plus period ticks, with config changes
// deferred to period boundaries so the waveform never glitches.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int DEF_HIGH   = DEF_HIGH_C,
    parameter int DEF_PERIOD = DEF_PERIOD_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_err,
    output logic             wave_out,
    output logic             tick,
    output logic             edge_rise,
    output logic             busy
);

    tb_state_t        state_q, state_d;
    logic [CNT_W-1:0] high_q, period_q, sh_high_q, sh_period_q;
    logic             pend_q, stop_pend_q, err_q;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             running, boundary, go_idle, xfer, cfg_good;

    assign running  = (state_q != IDLE);
    assign boundary = (state_q == RUN_LOW) && at_last;
    assign go_idle  = boundary && (stop_pend_q || stop);
    assign xfer     = cfg_valid && cfg_ready;
    assign cfg_good = cfg_ok(32'(cfg_high), 32'(cfg_period));

    // Held clear in IDLE so the first running cycle always starts at cnt=0.
    tb_period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!running),
        .en_i     (running),
        .limit_i  (period_q - CNT_W'(1)),
        .cnt_o    (cnt),
        .at_last_o(at_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && !stop) state_d = RUN_HIGH;
            RUN_HIGH: if (cnt == high_q - CNT_W'(1)) state_d = RUN_LOW;
            RUN_LOW:  if (at_last) state_d = go_idle ? IDLE : RUN_HIGH;
            default:  state_d = IDLE;
        endcase
    end

    assign wave_out  = (state_q == RUN_HIGH);
    assign edge_rise = (state_q == RUN_HIGH) && (cnt == '0);
    assign tick      = boundary;
    assign busy      = running;
    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            high_q      <= CNT_W'(DEF_HIGH);
            period_q    <= CNT_W'(DEF_PERIOD);
            sh_high_q   <= '0;
            sh_period_q <= '0;
            pend_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= xfer && !cfg_good;
            stop_pend_q <= running && !go_idle && (stop_pend_q || stop);
            // A shadow left pending when the run stopped is applied on the next idle cycle.
            if (pend_q && (boundary || !running)) begin
                high_q   <= sh_high_q;
                period_q <= sh_period_q;
                pend_q   <= 1'b0;
            end else if (xfer && cfg_good) begin
                if (!running) begin
                    high_q   <= cfg_high;
                    period_q <= cfg_period;
                end else begin
                    sh_high_q   <= cfg_high;
                    sh_period_q <= cfg_period;
                    pend_q      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/timebase_ctrl.md
Name: timebase_ctrl

Overview:
Programmable timebase controller that sequences a free-running cycle counter to produce a divided waveform and period ticks. Period and high-time are set at runtime through a valid/ready config port. New settings take effect only at period boundaries, so the output never glitches. It sits between the control/register logic and any consumer of slow enables or divided clocks (blinkers, scanners, sampling strobes).

Parameters:
CNT_W, 14, width of counter and config fields
DEF_HIGH, 500, high-time in clk cycles loaded at reset
DEF_PERIOD, 10000, period in clk cycles loaded at reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  level/pulse; begin generating from IDLE
stop  in  1  pulse; request graceful stop at end of current period
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept possible
cfg_high  in  CNT_W  requested high-time (cycles)
cfg_period  in  CNT_W  requested period (cycles)
cfg_err  out  1  1-cycle pulse: offered config rejected
wave_out  out  1  divided waveform, registered
tick  out  1  1-cycle pulse on last cycle of every period
edge_rise  out  1  1-cycle pulse on first cycle of every high phase
busy  out  1  state != IDLE

Behaviour:
- Decided: single clock clk; rst synchronous, active-high. It overrides all other inputs.
- Reset values:
  - state=IDLE, cnt=0
  - active high/period = DEF_HIGH/DEF_PERIOD
  - shadow and pending cleared, stop_pend=0
  - wave_out=tick=edge_rise=cfg_err=busy=0, cfg_ready=1
- States:
  - IDLE: wave_out=0, cnt held at 0.
  - RUN_HIGH: wave_out=1.
  - RUN_LOW: wave_out=0.
- Transitions:
  - IDLE to RUN_HIGH when start=1 and stop=0. Cycle N start gives wave_out=1 and edge_rise=1 at N+1, cnt=0.
  - RUN_HIGH to RUN_LOW when cnt==high-1.
  - RUN_LOW, on cnt==period-1 (tick=1 that cycle), goes to IDLE if stop_pend or a stop arrives that cycle. Otherwise cnt wraps to 0 and state goes to RUN_HIGH with edge_rise.
  - start while running is ignored. start and stop in the same IDLE cycle: stop wins, stays IDLE.
- Counter: cnt increments by 1 each running cycle and wraps at period-1 to 0, unsigned CNT_W. Result: exactly `high` cycles high and `period-high` cycles low.
- stop: sets stop_pend. Honoured only at the period boundary, so the last period is always complete. stop in IDLE has no effect.
- Config handshake: a transfer happens when cfg_valid & cfg_ready.
  - Valid only if period>=2 and 1<=high<=period-1. Otherwise cfg_err pulses the next cycle, the config is discarded and active values are unchanged.
  - Valid config in IDLE: active values update next cycle; cfg_ready stays 1.
  - Valid config while running: written to shadow, pending=1, cfg_ready=0. At the next boundary (cnt==period-1), active values load from shadow and pending clears; cfg_ready returns to 1 the following cycle.
  - Boundary and new config transfer in the same cycle is impossible, because cfg_ready=0 whenever pending=1.
- Boundary with pending config and stop_pend together: config is applied and state goes to IDLE.
- Reset mid-period or with config pending: shadow discarded and active values return to the defaults.

Decomposition:
- timebase_pkg:
  - typedef enum logic [1:0] {IDLE, RUN_HIGH, RUN_LOW} tb_state_t
  - localparams for default high/period
  - function cfg_ok(high, period) for the validity check
- Sub-module tb_period_counter (CNT_W): synchronous clear, enable, and compare-to-limit output `at_last`. Reused for the period boundary.

Test Plan:
1. rst 2 cycles; cfg high=3, period=8 in IDLE; start -> wave_out pattern 1,1,1,0,0,0,0,0 repeating; tick on every 8th cycle; edge_rise on every cycle-0.
2. Running at 3/8, offer high=2, period=5 mid-period -> cfg_ready=0 until boundary; current period finishes as 3/8, next is 2/5; cfg_ready=1 one cycle after the boundary.
3. Offer high=0, period=8 and high=8, period=8 and period=1 -> cfg_err pulses once each; waveform unchanged.
4. stop pulsed at cnt=1 of a 3/8 period -> period completes; busy=0 and wave_out=0 at cnt=0 of the next period; start and stop asserted together in IDLE -> stays IDLE.
5. rst asserted mid-high with pending config -> next cycle IDLE, outputs 0; after start, defaults 500/10000 are used (high 500 cycles, tick every 10000 cycles).
